// File: rtl/peripheral_ahb3_pkg.sv
// rtl/peripheral_ahb3_pkg.sv - AHB3-Lite encodings, slave FSM states and byte-lane helpers
package peripheral_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_B8  = 3'b000;
  localparam logic [2:0] HSIZE_B16 = 3'b001;
  localparam logic [2:0] HSIZE_B32 = 3'b010;
  localparam logic [2:0] HSIZE_B64 = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    FSM_IDLE,
    FSM_WAIT,
    FSM_ERR1,
    FSM_ERR2
  } fsm_state_t;

  // Little-endian lane mask within a 64-bit beat; narrower buses use the low bits.
  function automatic logic [7:0] byte_enable(input logic [2:0] size, input logic [2:0] addr_lo);
    logic [7:0] be;
    case (size)
      HSIZE_B8:  be = 8'b0000_0001 << addr_lo;
      HSIZE_B16: be = 8'b0000_0011 << {addr_lo[2:1], 1'b0};
      HSIZE_B32: be = 8'b0000_1111 << {addr_lo[2], 2'b00};
      HSIZE_B64: be = 8'b1111_1111;
      default:   be = 8'b1111_1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [2:0] addr_lo);
    logic bad;
    case (size)
      HSIZE_B8:  bad = 1'b0;
      HSIZE_B16: bad = addr_lo[0];
      HSIZE_B32: bad = |addr_lo[1:0];
      default:   bad = |addr_lo;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/peripheral_slave_ahb3_sram_sram_be.sv
// rtl/peripheral_slave_ahb3_sram_sram_be.sv - word-wide SRAM with byte-enable writes and asynchronous read
module peripheral_sram_be
  import peripheral_ahb3_pkg::*;
#(
  parameter int MEM_BYTES  = 4096,
  parameter int HDATA_SIZE = 32,
  localparam int BYTES     = HDATA_SIZE / 8,
  localparam int DEPTH     = MEM_BYTES / BYTES,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BYTES-1:0]      be,
  input  logic [AW-1:0]         addr,
  input  logic [HDATA_SIZE-1:0] wdata,
  output logic [HDATA_SIZE-1:0] rdata
);

  logic [HDATA_SIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) begin
          mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // The address comes from the slave's latched transfer, so the read is effectively registered.
  assign rdata = mem_q[addr];

endmodule

// File: rtl/peripheral_slave_ahb3_sram.sv
// rtl/peripheral_slave_ahb3_sram.sv - AHB3-Lite SRAM slave with programmable wait states and ERROR response
module peripheral_slave_ahb3_sram
  import peripheral_ahb3_pkg::*;
#(
  parameter int HADDR_SIZE  = 16,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int         BYTES     = HDATA_SIZE / 8;
  localparam int         OFF_W     = $clog2(BYTES);
  localparam int         MEM_AW    = $clog2(MEM_BYTES);
  localparam logic [2:0] MAX_SIZE  = 3'(OFF_W);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  fsm_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q, hresp_d;

  logic                  accept;
  logic                  xfer_err;
  logic                  mem_we;
  logic                  rd_final;
  logic [7:0]            be_all;
  logic [HDATA_SIZE-1:0] mem_rdata;
  logic                  unused_ok;

  assign accept   = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign xfer_err = (HSIZE > MAX_SIZE) | misaligned(HSIZE, 3'(HADDR[OFF_W-1:0]));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      // Both ready states end a data phase, so a new address phase can land here.
      FSM_IDLE, FSM_ERR2: begin
        state_d = FSM_IDLE;
        pend_d  = 1'b0;
        if (accept) begin
          addr_d  = HADDR[MEM_AW-1:0];
          write_d = HWRITE;
          size_d  = HSIZE;
          if (xfer_err) begin
            state_d = FSM_ERR1;
          end else begin
            pend_d = 1'b1;
            if (WAIT_STATES != 0) begin
              state_d = FSM_WAIT;
              cnt_d   = WAIT_INIT;
            end
          end
        end
      end
      FSM_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = FSM_IDLE;
        end
      end
      FSM_ERR1: state_d = FSM_ERR2;
      default:  state_d = FSM_IDLE;
    endcase
    hreadyout_d = (state_d == FSM_IDLE) | (state_d == FSM_ERR2);
    hresp_d     = ((state_d == FSM_ERR1) | (state_d == FSM_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= FSM_IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // A pending transfer in IDLE is in its final (ready) data-phase cycle.
  assign be_all   = byte_enable(size_q, 3'(addr_q[OFF_W-1:0]));
  assign mem_we   = pend_q & write_q & (state_q == FSM_IDLE) & ~HRESET;
  assign rd_final = pend_q & ~write_q & (state_q == FSM_IDLE);

  peripheral_sram_be #(
    .MEM_BYTES  (MEM_BYTES),
    .HDATA_SIZE (HDATA_SIZE)
  ) u_sram (
    .clk   (HCLK),
    .we    (mem_we),
    .be    (be_all[BYTES-1:0]),
    .addr  (addr_q[MEM_AW-1:OFF_W]),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

  assign HRDATA    = rd_final ? mem_rdata : '0;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HADDR[HADDR_SIZE-1:MEM_AW], be_all};

endmodule

// File: tb/tb_peripheral_slave_ahb3_sram.sv
// tb/tb_peripheral_slave_ahb3_sram.sv - self-checking bench for the AHB3-Lite SRAM slave at three wait-state settings
module tb_peripheral_slave_ahb3_sram;

  localparam int N = 3;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [15:0] addr;
    logic [31:0] wdata;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hreset    [N];
  logic        hsel      [N];
  logic        hwrite    [N];
  logic        hreadyout [N];
  logic        hresp     [N];
  logic [15:0] haddr     [N];
  logic [31:0] hwdata    [N];
  logic [31:0] hrdata    [N];
  logic [2:0]  hsize     [N];
  logic [1:0]  htrans    [N];
  logic [2:0]  hburst    = 3'b001;
  logic [3:0]  hprot     = 4'b0011;
  logic        hmastlock = 1'b0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    peripheral_slave_ahb3_sram #(
      .HADDR_SIZE  (16),
      .HDATA_SIZE  (32),
      .MEM_BYTES   (4096),
      .WAIT_STATES (g == 0 ? 0 : (g == 1 ? 2 : 3))
    ) u_dut (
      .HCLK      (clk),
      .HRESET    (hreset[g]),
      .HSEL      (hsel[g]),
      .HADDR     (haddr[g]),
      .HWDATA    (hwdata[g]),
      .HRDATA    (hrdata[g]),
      .HWRITE    (hwrite[g]),
      .HSIZE     (hsize[g]),
      .HBURST    (hburst),
      .HPROT     (hprot),
      .HTRANS    (htrans[g]),
      .HMASTLOCK (hmastlock),
      .HREADY    (hreadyout[g]),
      .HREADYOUT (hreadyout[g]),
      .HRESP     (hresp[g])
    );
  end

  logic [7:0]  mm [N][4096];
  bit          kn [N][4096];
  op_t         q [$];
  logic [31:0] last_rdata;
  int          checks = 0;
  int          errors = 0;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit op_err(input op_t o);
    int bytes = 1 << o.size;
    return o.sel && o.trans[1] && (o.size > 3'd2 || (int'(o.addr) % bytes) != 0);
  endfunction

  function automatic bit op_mem(input op_t o);
    return o.sel && o.trans[1] && !op_err(o);
  endfunction

  function automatic void model_write(input int d, input op_t o);
    for (int b = 0; b < (1 << o.size); b++) begin
      int a = (int'(o.addr) + b) % 4096;
      mm[d][a] = o.wdata[8*(a%4) +: 8];
      kn[d][a] = 1'b1;
    end
  endfunction

  function automatic bit model_read(input int d, input op_t o, output logic [31:0] w);
    int base = (int'(o.addr) % 4096) / 4 * 4;
    w = {mm[d][base+3], mm[d][base+2], mm[d][base+1], mm[d][base]};
    return kn[d][base] && kn[d][base+1] && kn[d][base+2] && kn[d][base+3];
  endfunction

  task automatic push(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                      input logic [15:0] a, input logic [31:0] wd);
    op_t o;
    o.sel = sel; o.trans = tr; o.wr = wr; o.size = sz; o.addr = a; o.wdata = wd;
    q.push_back(o);
  endtask

  task automatic wr_op(input logic [15:0] a, input logic [2:0] sz, input logic [31:0] wd);
    push(1'b1, T_NONSEQ, 1'b1, sz, a, wd);
  endtask

  task automatic rd_op(input logic [15:0] a, input logic [2:0] sz);
    push(1'b1, T_NONSEQ, 1'b0, sz, a, 32'h0);
  endtask

  task automatic drive_addr(input int d, input op_t o);
    hsel[d] = o.sel; htrans[d] = o.trans; hwrite[d] = o.wr; hsize[d] = o.size; haddr[d] = o.addr;
  endtask

  task automatic drive_idle(input int d);
    hsel[d] = 1'b0; htrans[d] = T_IDLE; hwrite[d] = 1'b0; hsize[d] = 3'd0; haddr[d] = 16'h0;
  endtask

  // Pipelined master: issues the queued address phases, checks every data-phase cycle against the model.
  task automatic run(input int d);
    int          ai = 0;
    bit          dp_v = 1'b0;
    op_t         dp;
    int          waits = 0;
    int          cyc = 0;
    bit          acc;
    bit          kw;
    logic [31:0] w;
    int          ws = ws_of(d);
    dp = '0;
    if (q.size() > 0) drive_addr(d, q[0]); else drive_idle(d);
    while (1) begin
      @(negedge clk);
      acc = 1'b0;
      if (dp_v) begin
        if (!hreadyout[d]) begin
          waits++;
          check("wait_hresp", hresp[d], op_err(dp));
          check("wait_hrdata", hrdata[d], 32'h0);
        end else begin
          check("final_hresp", hresp[d], op_err(dp));
          check("wait_cycles", waits, op_err(dp) ? 1 : (op_mem(dp) ? ws : 0));
          if (op_mem(dp) && !dp.wr) begin
            kw = model_read(d, dp, w);
            if (kw) check("read_data", hrdata[d], w);
            last_rdata = hrdata[d];
          end else begin
            check("idle_hrdata", hrdata[d], 32'h0);
          end
          if (op_mem(dp) && dp.wr) model_write(d, dp);
          dp_v = 1'b0;
        end
      end
      if (hreadyout[d] && ai < q.size()) acc = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        dp    = q[ai];
        ai++;
        dp_v  = 1'b1;
        waits = 0;
        hwdata[d] = dp.wr ? dp.wdata : $urandom();
        if (ai < q.size()) drive_addr(d, q[ai]); else drive_idle(d);
      end else if (!dp_v && ai >= q.size()) begin
        break;
      end
      if (cyc > 2000) begin
        errors++;
        $error("FAIL timeout: dut %0d ran %0d cycles, limit 2000", d, cyc);
        break;
      end
    end
    q.delete();
  endtask

  initial begin
    op_t o;
    for (int d = 0; d < N; d++) begin
      hreset[d] = 1'b1;
      hwdata[d] = 32'h0;
      drive_idle(d);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      check("reset_hreadyout", hreadyout[d], 1'b1);
      check("reset_hresp", hresp[d], 1'b0);
      check("reset_hrdata", hrdata[d], 32'h0);
      hreset[d] = 1'b0;
    end
    @(posedge clk);
    #1;

    wr_op(16'h0100, 3'd2, 32'hDEADBEEF);
    rd_op(16'h0100, 3'd2);
    run(0);
    check("raw_word", last_rdata, 32'hDEADBEEF);

    wr_op(16'h0040, 3'd2, 32'h11223344);
    wr_op(16'h0042, 3'd0, 32'h00AA0000);
    wr_op(16'h0040, 3'd1, 32'h0000BBCC);
    rd_op(16'h0040, 3'd2);
    run(0);
    check("byte_lanes", last_rdata, 32'h11AABBCC);

    wr_op(16'h1004, 3'd2, 32'h5A5A5A5A);
    rd_op(16'h0004, 3'd2);
    run(0);
    check("alias", last_rdata, 32'h5A5A5A5A);

    rd_op(16'h0102, 3'd2);
    rd_op(16'h0000, 3'd3);
    wr_op(16'h0006, 3'd2, 32'hFFFFFFFF);
    push(1'b0, T_NONSEQ, 1'b1, 3'd2, 16'h0004, 32'h01010101);
    rd_op(16'h0004, 3'd2);
    run(0);
    check("misaligned_no_write", last_rdata, 32'h5A5A5A5A);

    for (int i = 0; i < 4; i++) wr_op(16'(16'h0200 + 4*i), 3'd2, 32'hA0000000 + i);
    rd_op(16'h0200, 3'd2);
    push(1'b1, T_SEQ,  1'b0, 3'd2, 16'h0204, 32'h0);
    push(1'b1, T_BUSY, 1'b0, 3'd2, 16'h0208, 32'h0);
    push(1'b1, T_SEQ,  1'b0, 3'd2, 16'h0208, 32'h0);
    push(1'b1, T_SEQ,  1'b0, 3'd2, 16'h020C, 32'h0);
    rd_op(16'h0102, 3'd2);
    run(1);
    check("burst_last_beat", last_rdata, 32'hA0000003);

    wr_op(16'h0010, 3'd2, 32'hCAFEF00D);
    run(2);
    o.sel = 1'b1; o.trans = T_NONSEQ; o.wr = 1'b1; o.size = 3'd2; o.addr = 16'h0010; o.wdata = 32'h0BADBAD0;
    drive_addr(2, o);
    @(posedge clk);
    #1;
    hwdata[2] = o.wdata;
    drive_idle(2);
    @(negedge clk);
    check("rst_mid_waiting", hreadyout[2], 1'b0);
    @(posedge clk);
    #1;
    hreset[2] = 1'b1;
    @(posedge clk);
    #1;
    hreset[2] = 1'b0;
    @(negedge clk);
    check("rst_mid_hreadyout", hreadyout[2], 1'b1);
    check("rst_mid_hresp", hresp[2], 1'b0);
    check("rst_mid_hrdata", hrdata[2], 32'h0);
    @(posedge clk);
    #1;
    rd_op(16'h0010, 3'd2);
    run(2);
    check("reset_discard", last_rdata, 32'hCAFEF00D);

    for (int d = 0; d < N; d++) begin
      for (int i = 0; i < 16; i++) wr_op(16'(16'h0300 + 4*i), 3'd2, $urandom());
      for (int i = 0; i < 60; i++) begin
        int r = $urandom_range(0, 9);
        o.sel   = ($urandom_range(0, 9) != 0);
        o.trans = (r < 6) ? T_NONSEQ : ((r < 8) ? T_SEQ : ((r == 8) ? T_BUSY : T_IDLE));
        o.size  = 3'($urandom_range(0, 3));
        o.wr    = 1'($urandom_range(0, 1));
        o.wdata = $urandom();
        o.addr  = 16'(16'h0300 + $urandom_range(0, 63)) | 16'($urandom_range(0, 15) << 12);
        if ($urandom_range(0, 3) != 0) o.addr = o.addr & ~16'((1 << o.size) - 1);
        q.push_back(o);
      end
      run(d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/peripheral_slave_ahb3_sram.md
Name: peripheral_slave_ahb3_sram

Overview:
- AHB3-Lite slave (responder) with internal byte-addressable SRAM, programmable wait states and a two-cycle ERROR response.
- Connects to one slave port of peripheral_msi_ahb3. Serves as the synthesizable endpoint and as the slave model behind the interconnect in system benches.
- Supports single and burst transfers (NONSEQ/SEQ/BUSY) of byte, halfword and word size.

Parameters:
- HADDR_SIZE, 16, address width.
- HDATA_SIZE, 32, data width; must be 32 or 64.
- MEM_BYTES, 4096, SRAM size in bytes; must be a power of 2. Memory is indexed by HADDR modulo MEM_BYTES (aliasing).
- WAIT_STATES, 0, number of HREADYOUT=0 cycles inserted in each OKAY data phase; range 0..15.

Ports:
- HCLK  in  1  clock; all logic is on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from the interconnect.
- HADDR  in  HADDR_SIZE  transfer address.
- HWDATA  in  HDATA_SIZE  write data, valid in the data phase.
- HRDATA  out  HDATA_SIZE  read data.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type; informational only.
- HPROT  in  4  protection; ignored.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HMASTLOCK  in  1  ignored.
- HREADY  in  1  bus ready, the qualifier for the address phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Clock and reset: one clock, HCLK; reset HRESET is synchronous and active-high.
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, pending transfer cleared.
  - SRAM contents are not reset.
- Reset mid-transfer: the transfer is aborted and any pending write is discarded. The next cycle is IDLE with HREADYOUT=1.
- Address-phase acceptance:
  - A transfer is accepted when HSEL & HREADY & HTRANS[1] at a rising edge.
  - At acceptance, latch HADDR, HWRITE and HSIZE.
  - IDLE or BUSY with HSEL & HREADY gives a zero-wait OKAY data phase with no memory access.
- Transfer checks, made at acceptance:
  - ERROR if HSIZE > log2(HDATA_SIZE/8).
  - ERROR if the address is misaligned for HSIZE (e.g. halfword with HADDR[0]=1; word with HADDR[1:0]!=0).
  - Otherwise OKAY.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: accept OKAY with WAIT_STATES=0 -> stay IDLE; the data phase completes in the next cycle with HREADYOUT=1.
  - IDLE: accept OKAY with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES.
  - IDLE: accept ERROR -> ERR1.
  - WAIT: HREADYOUT=0, counter decrements each cycle; when it reaches 0 -> IDLE, and that cycle has HREADYOUT=1 (final data-phase cycle).
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1 -> IDLE. A new address phase may be accepted in ERR2 because HREADY=1.
- Latency: the data phase lasts 1+WAIT_STATES cycles for OKAY and exactly 2 cycles for ERROR.
- Writes:
  - HWDATA is sampled in the final data-phase cycle.
  - Byte lanes are derived from the latched HSIZE and HADDR low bits, little-endian.
  - An ERROR transfer never writes.
- Reads:
  - HRDATA carries the full memory word at the latched address in the final data-phase cycle; it is 0 in all other cycles.
  - Byte-lane selection is the master's responsibility.
- Back-to-back transfers:
  - A new address phase is accepted in the same cycle a data phase completes (pipelined).
  - Read-after-write to the same address in consecutive transfers must return the newly written data.
- HSEL=0 with HREADY=1: no acceptance, FSM stays IDLE, outputs OKAY/ready.

Decomposition:
- Package peripheral_ahb3_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ, HSIZE_B8/B16/B32/B64, HRESP_OKAY/ERROR constants;
  - an fsm_state_t enum (IDLE, WAIT, ERR1, ERR2);
  - a function that maps (HSIZE, addr low bits) to a byte-enable vector.
- Sub-module peripheral_sram_be:
  - single-port array of HDATA_SIZE words with byte-enable writes and asynchronous read from a registered address;
  - parameters MEM_BYTES and HDATA_SIZE.

Test Plan:
- Reset with HRESET=1 for 2 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0. Assert HRESET during a WAIT_STATES=3 write -> write to 0x0010 is discarded; a later read returns the prior value.
- WAIT_STATES=0: write word 0xDEADBEEF at 0x0100, then read 0x0100 back-to-back -> read data phase shows HREADYOUT=1, HRESP=0, HRDATA=0xDEADBEEF, with no wait cycles.
- Byte lanes: write word 0x11223344 at 0x0040, then byte 0xAA at 0x0042 (HSIZE=0, HWDATA=0x00AA0000), then halfword 0xBBCC at 0x0040 -> word read at 0x0040 returns 0x11AABBCC.
- WAIT_STATES=2: 4-beat INCR4 read from 0x0200 (NONSEQ, then SEQ) -> each beat shows 2 cycles HREADYOUT=0 then 1 ready cycle; a BUSY inserted between beats gives a zero-wait OKAY.
- Errors: word read at 0x0102 and HSIZE=3 at 0x0000 (HDATA_SIZE=32) -> each gives HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1. A misaligned write at 0x0006 leaves memory unchanged.
- Aliasing (MEM_BYTES=4096): write 0x5A5A5A5A at 0x1004 -> read at 0x0004 returns 0x5A5A5A5A.
